// File: rtl/lzss_pkg.sv
// Shared LZSS types and constants for the compressor/decompressor pair.
// Token widths follow the default 16-byte window and 4-bit length field.
package lzss_pkg;

    localparam int SYMBOL_W     = 8;
    localparam int DEF_WINDOW   = 16;
    localparam int DEF_LEN_W    = 4;
    localparam int DEF_OFFSET_W = $clog2(DEF_WINDOW) + 1;

    typedef struct packed {
        logic                    is_match;
        logic [SYMBOL_W-1:0]     literal;
        logic [DEF_OFFSET_W-1:0] offset;
        logic [DEF_LEN_W-1:0]    length;
    } lzss_token_t;

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } lzss_dec_state_t;

endpackage

// File: rtl/lzss_decoder_if.sv
// Token-in / byte-out handshake bundle for the LZSS decoder.
// master = token source and byte sink, slave = decoder.
interface lzss_decoder_if #(
    parameter int WINDOW = 16,
    parameter int LEN_W  = 4
);
    import lzss_pkg::*;

    localparam int OFFSET_W = $clog2(WINDOW) + 1;

    logic                tok_valid;
    logic                tok_ready;
    logic                tok_is_match;
    logic [SYMBOL_W-1:0] tok_literal;
    logic [OFFSET_W-1:0] tok_offset;
    logic [LEN_W-1:0]    tok_length;
    logic                out_valid;
    logic                out_ready;
    logic [SYMBOL_W-1:0] out_data;
    logic                busy;
    logic                err;

    modport master (
        output tok_valid, tok_is_match, tok_literal, tok_offset, tok_length, out_ready,
        input  tok_ready, out_valid, out_data, busy, err
    );

    modport slave (
        input  tok_valid, tok_is_match, tok_literal, tok_offset, tok_length, out_ready,
        output tok_ready, out_valid, out_data, busy, err
    );
endinterface

// File: rtl/lzss_history_buf.sv
// Sliding-window history: synchronous write, combinational read.
// Contents are deliberately not reset; the fill counter guards stale entries.
module lzss_history_buf
    import lzss_pkg::*;
#(
    parameter int WINDOW = 16,
    localparam int PTR_W = $clog2(WINDOW)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [PTR_W-1:0]    waddr,
    input  logic [SYMBOL_W-1:0] wdata,
    input  logic [PTR_W-1:0]    raddr,
    output logic [SYMBOL_W-1:0] rdata
);

    logic [SYMBOL_W-1:0] mem [WINDOW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lzss_decoder.sv
// LZSS decompressor: expands literal/(offset,length) tokens into a byte stream,
// one byte per cycle, copying matches out of its own history window.
module lzss_decoder
    import lzss_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int LEN_W  = 4
) (
    input logic           clk,
    input logic           rst_,
    lzss_decoder_if.slave bus
);

    localparam int PTR_W    = $clog2(WINDOW);
    localparam int OFFSET_W = PTR_W + 1;

    lzss_dec_state_t     state, state_nxt;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [OFFSET_W-1:0] fill;
    logic [LEN_W-1:0]    remaining;
    logic [SYMBOL_W-1:0] out_data, hist_rdata, hist_wdata;
    logic                out_valid, err;

    logic slot_free, tok_ready, accept, legal;
    logic lit_acc, match_ok, match_bad, copy_step, hist_we;

    assign slot_free = !out_valid || bus.out_ready;
    assign accept    = bus.tok_valid && tok_ready;
    // legality is judged against fill before this cycle's update
    assign legal     = (bus.tok_offset != '0) && (bus.tok_offset <= fill) && (bus.tok_length != '0);
    assign lit_acc   = accept && !bus.tok_is_match;
    assign match_ok  = accept && bus.tok_is_match && legal;
    assign match_bad = accept && bus.tok_is_match && !legal;
    assign copy_step = (state == COPY) && slot_free;

    always_ff @(posedge clk) begin
        if (!rst_) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (match_ok) state_nxt = COPY;
            COPY: if (copy_step && remaining == LEN_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tok_ready  = (state == IDLE) && slot_free;
        hist_we    = lit_acc || copy_step;
        hist_wdata = (state == COPY) ? hist_rdata : bus.tok_literal;
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            remaining <= '0;
            err       <= 1'b0;
        end else begin
            if (hist_we) begin
                out_data  <= hist_wdata;
                out_valid <= 1'b1;
                wr_ptr    <= wr_ptr + 1'b1;
                if (fill != OFFSET_W'(WINDOW)) fill <= fill + 1'b1;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
            if (match_ok) begin
                // offset WINDOW truncates to 0, i.e. the slot about to be overwritten
                rd_ptr    <= wr_ptr - bus.tok_offset[PTR_W-1:0];
                remaining <= bus.tok_length;
            end
            if (copy_step) begin
                rd_ptr    <= rd_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (match_bad) err <= 1'b1;
        end
    end

    lzss_history_buf #(.WINDOW(WINDOW)) u_hist (
        .clk   (clk),
        .we    (hist_we),
        .waddr (wr_ptr),
        .wdata (hist_wdata),
        .raddr (rd_ptr),
        .rdata (hist_rdata)
    );

    assign bus.tok_ready = tok_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.busy      = (state == COPY);
    assign bus.err       = err;

endmodule

// File: tb/tb_lzss_decoder.sv
// Directed bench for lzss_decoder: literals, overlapping and wrapping matches,
// backpressure, illegal tokens and reset during a copy.
module tb_lzss_decoder;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic       held = 1'b0;
    logic [7:0] held_data = '0;

    always #5 clk = ~clk;

    lzss_decoder_if #(.WINDOW(16), .LEN_W(4)) bus ();

    lzss_decoder #(.WINDOW(16), .LEN_W(4)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // byte sink: a transfer happens at the posedge following a negedge with valid && ready
    always @(negedge clk) begin
        if (!rst_) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", {31'h0, bus.out_valid}, 32'h1);
                check("hold_data", {24'h0, bus.out_data}, {24'h0, held_data});
            end
            if (bus.out_valid && !bus.out_ready) begin
                held      = 1'b1;
                held_data = bus.out_data;
            end else begin
                held = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
        end
    end

    task automatic do_reset();
        rst_          = 1'b0;
        bus.tok_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;
        got.delete();
    endtask

    // returns at 1ns after the edge that accepted the token
    task automatic send(input logic m, input logic [7:0] lit, input logic [4:0] off, input logic [3:0] len);
        int n = 0;
        bus.tok_valid    = 1'b1;
        bus.tok_is_match = m;
        bus.tok_literal  = lit;
        bus.tok_offset   = off;
        bus.tok_length   = len;
        @(negedge clk);
        while (!bus.tok_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("tok_accept_timeout", 32'(n), 32'h0);
        @(posedge clk);
        #1;
        bus.tok_valid = 1'b0;
    endtask

    task automatic expect_bytes(input string tag);
        for (int i = 0; i < 60 && got.size() < exp_q.size(); i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check(tag, (i < got.size()) ? {24'h0, got[i]} : 32'hdead, {24'h0, exp_q[i]});
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        int nbusy, nblock;
        logic [3:0] pat;

        bus.tok_valid    = 1'b0;
        bus.tok_is_match = 1'b0;
        bus.tok_literal  = '0;
        bus.tok_offset   = '0;
        bus.tok_length   = '0;
        bus.out_ready    = 1'b1;

        do_reset();
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_out_data", {24'h0, bus.out_data}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_err", {31'h0, bus.err}, 32'h0);
        check("rst_tok_ready", {31'h0, bus.tok_ready}, 32'h1);

        // literals ABC, one cycle latency each, back to back
        send(1'b0, 8'h41, 5'd0, 4'd0);
        check("lit_a", {23'h0, bus.out_valid, bus.out_data}, 32'h141);
        send(1'b0, 8'h42, 5'd0, 4'd0);
        check("lit_b", {23'h0, bus.out_valid, bus.out_data}, 32'h142);
        send(1'b0, 8'h43, 5'd0, 4'd0);
        check("lit_c", {23'h0, bus.out_valid, bus.out_data}, 32'h143);
        check("lit_err", {31'h0, bus.err}, 32'h0);
        exp_q = {8'h41, 8'h42, 8'h43};
        expect_bytes("lit_abc");

        // match 3,3 replays ABC
        send(1'b1, 8'h00, 5'd3, 4'd3);
        check("m33_busy", {31'h0, bus.busy}, 32'h1);
        check("m33_no_emit", {31'h0, bus.out_valid}, 32'h0);
        nbusy  = 0;
        nblock = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (!bus.tok_ready) nblock++;
        end
        check("m33_busy_cycles", 32'(nbusy), 32'd3);
        check("m33_ready_low", 32'(nblock), 32'd3);
        exp_q = {8'h41, 8'h42, 8'h43};
        expect_bytes("m33");

        // overlap: 0x5A then offset 1 length 5
        send(1'b0, 8'h5a, 5'd0, 4'd0);
        send(1'b1, 8'h00, 5'd1, 4'd5);
        repeat (6) exp_q.push_back(8'h5a);
        expect_bytes("overlap");

        // backpressure during a length-4 match
        send(1'b0, 8'h11, 5'd0, 4'd0);
        send(1'b0, 8'h22, 5'd0, 4'd0);
        send(1'b0, 8'h33, 5'd0, 4'd0);
        send(1'b0, 8'h44, 5'd0, 4'd0);
        exp_q = {8'h11, 8'h22, 8'h33, 8'h44};
        expect_bytes("bp_lits");
        pat = 4'b1001;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    bus.out_ready = pat[i % 4];
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
            send(1'b1, 8'h00, 5'd4, 4'd4);
        join
        exp_q = {8'h11, 8'h22, 8'h33, 8'h44};
        expect_bytes("bp_match");

        // illegal: offset 1 from empty window
        do_reset();
        send(1'b1, 8'h00, 5'd1, 4'd2);
        repeat (3) @(posedge clk);
        #1;
        check("ill_empty_err", {31'h0, bus.err}, 32'h1);
        check("ill_empty_busy", {31'h0, bus.busy}, 32'h0);
        check("ill_empty_nout", 32'(got.size()), 32'd0);

        // illegal: offset 3 after 2 literals
        do_reset();
        send(1'b0, 8'h01, 5'd0, 4'd0);
        send(1'b0, 8'h02, 5'd0, 4'd0);
        check("ill3_err_before", {31'h0, bus.err}, 32'h0);
        send(1'b1, 8'h00, 5'd3, 4'd1);
        repeat (3) @(posedge clk);
        #1;
        check("ill3_err", {31'h0, bus.err}, 32'h1);
        check("ill3_nout", 32'(got.size()), 32'd2);

        // illegal: offset 0 after 2 literals
        do_reset();
        send(1'b0, 8'h01, 5'd0, 4'd0);
        send(1'b0, 8'h02, 5'd0, 4'd0);
        send(1'b1, 8'h00, 5'd0, 4'd1);
        repeat (3) @(posedge clk);
        #1;
        check("ill0_err", {31'h0, bus.err}, 32'h1);
        check("ill0_nout", 32'(got.size()), 32'd2);
        check("ill0_tok_ready", {31'h0, bus.tok_ready}, 32'h1);

        // illegal: length 0 with a legal offset
        do_reset();
        send(1'b0, 8'h01, 5'd0, 4'd0);
        send(1'b1, 8'h00, 5'd1, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        check("illlen_err", {31'h0, bus.err}, 32'h1);
        check("illlen_nout", 32'(got.size()), 32'd1);

        // wrap: 20 literals, then offset 16 length 2
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(1'b0, 8'h80 + 8'(i), 5'd0, 4'd0);
            exp_q.push_back(8'h80 + 8'(i));
        end
        expect_bytes("wrap_lits");
        send(1'b1, 8'h00, 5'd16, 4'd2);
        exp_q = {8'h84, 8'h85};
        expect_bytes("wrap_match");
        check("wrap_err", {31'h0, bus.err}, 32'h0);

        // reset in the middle of a copy
        do_reset();
        send(1'b0, 8'h10, 5'd0, 4'd0);
        send(1'b1, 8'h00, 5'd1, 4'd10);
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy_pre", {31'h0, bus.busy}, 32'h1);
        rst_ = 1'b0;
        @(posedge clk);
        #1;
        check("mid_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("mid_out_data", {24'h0, bus.out_data}, 32'h0);
        check("mid_busy", {31'h0, bus.busy}, 32'h0);
        check("mid_err", {31'h0, bus.err}, 32'h0);
        rst_ = 1'b1;
        got.delete();
        send(1'b0, 8'h77, 5'd0, 4'd0);
        check("mid_fresh", {23'h0, bus.out_valid, bus.out_data}, 32'h177);
        exp_q = {8'h77};
        expect_bytes("mid_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lzss_decoder.md
# lzss_decoder

LZSS decompressor core: consumes the literal / (offset, length) token stream produced by the compressor and regenerates the original byte stream. It keeps a sliding history window and emits one byte per cycle over a valid/ready output, expanding match tokens by copying from its own history, including overlapping copies. It sits at the decompression end of the LZSS datapath, mirroring the compressor's match-search front end.

## Interface
- WINDOW, 16: history depth in bytes; power of two, at least 2.
- LEN_W, 4: width of the length field. Legal match lengths are 1..2^LEN_W-1.
- OFFSET_W (localparam): $clog2(WINDOW)+1 bits, so offset WINDOW is encodable.
- clk  in  1  rising-edge clock.
- rst_  in  1  synchronous, active-low reset.
- tok_valid  in  1  token present.
- tok_ready  out  1  token accepted when tok_valid && tok_ready.
- tok_is_match  in  1  1 = match token, 0 = literal token.
- tok_literal  in  8  literal byte; ignored for matches.
- tok_offset  in  OFFSET_W  match distance, 1-indexed: 1 = most recently emitted byte.
- tok_length  in  LEN_W  number of bytes to copy.
- out_valid  out  1  out_data holds a decoded byte.
- out_ready  in  1  sink accepts the byte when out_valid && out_ready.
- out_data  out  8  decoded byte.
- busy  out  1  high while in COPY.
- err  out  1  sticky illegal-token flag; cleared only by reset.

## Operation
- State machine has two states, IDLE and COPY.
- Output register slot is free when !out_valid || out_ready.
- tok_ready = (state==IDLE) && slot free. It is combinational and never depends on tok_valid.
- **IDLE, literal accepted:**
  - out_data <= tok_literal; out_valid <= 1.
  - hist[wr_ptr] <= tok_literal; wr_ptr++.
  - fill++, saturating at WINDOW.
- **IDLE, match accepted and legal** (1 <= offset <= fill, length >= 1):
  - rd_ptr <= wr_ptr - offset, taken modulo WINDOW.
  - remaining <= length; go to COPY.
  - No byte is emitted in this cycle.
- **IDLE, match accepted and illegal** (offset 0, offset > fill, or length 0):
  - The token is consumed and err <= 1.
  - No output is produced and no state change occurs.
- **COPY**, each cycle the slot is free:
  - out_data <= hist[rd_ptr]; out_valid <= 1.
  - hist[wr_ptr] <= hist[rd_ptr].
  - rd_ptr++, wr_ptr++, fill++ (saturating), remaining--.
  - When remaining==1 before the decrement, return to IDLE.
- **COPY** with the slot not free: all state holds.
- When out_valid && out_ready and nothing new is loaded, out_valid <= 0.
- Pointers are $clog2(WINDOW) bits and wrap naturally modulo WINDOW.
- Overlapping copies (offset < length) replicate correctly, because a history byte written in cycle n is readable in cycle n+1. For example, offset 1 with length L repeats the last byte L times.

## Timing
- Reset values:
  - out_valid=0, out_data=0, busy=0, err=0.
  - state=IDLE; wr_ptr, rd_ptr, fill and remaining = 0.
  - History contents are don't-care; fill=0 makes them unreachable.
- Literal: accepted in cycle n, byte appears with out_valid in cycle n+1.
- Match of length L: accepted in cycle n, bytes appear in cycles n+2 .. n+L+1 with out_ready held high.
- tok_ready is low from cycle n+1 through the cycle the last byte is loaded.
- Back-to-back literals sustain one byte per cycle when out_ready is held high.
- Backpressure:
  - out_data and out_valid are stable while out_valid && !out_ready.
  - COPY stalls without losing or duplicating bytes.
- Reset asserted mid-COPY: abort on the next edge and return all registers to their reset values. The remaining bytes are discarded.
- The err check uses fill before the update in the same cycle.

## Structure
- Package lzss_pkg holds:
  - SYMBOL_W = 8.
  - Typedef lzss_token_t: is_match, literal, offset, length. This type is shared with the compressor's output formatter.
  - Enum lzss_dec_state_t {IDLE, COPY}.
- Sub-module lzss_history_buf (WINDOW x 8 register array):
  - One synchronous write port (we, waddr, wdata).
  - One combinational read port (raddr -> rdata).
  - No reset on contents.
- Top level holds the FSM, pointers, fill counter, output register and error logic.

## Test plan
- Reset, then literals 0x41, 0x42, 0x43 with out_ready=1 → out_data 0x41, 0x42, 0x43 on three consecutive cycles, each one cycle after acceptance; err=0.
- After literals "ABC", match offset=3, length=3 → outputs 0x41, 0x42, 0x43; busy high for 3 cycles; tok_ready low until the last byte is loaded.
- Literal 0x5A, then match offset=1, length=5 → six consecutive 0x5A bytes (overlap case).
- out_ready toggled 1,0,0,1,… during a length-4 match → each byte held stable while stalled; exactly 4 bytes delivered in order.
- Illegal tokens, from an empty window and after 2 literals respectively:
  - offset=1 → err=1, no output.
  - offset=3 → err=1, no output.
  - offset=0 → err=1, no output.
- Decode >WINDOW literals followed by match offset=WINDOW, length=2 (wrap-around) → correct bytes.
- Assert rst_=0 mid-COPY → all outputs at reset values on the next cycle; a fresh literal then decodes normally.
